// File: rtl/idc_conv_sequencer_pkg.sv
// Shared constants for the IDC conversion sequencer.
//   - Default widths for the filter interface and the output sample.
//   - Launch pulse length and timeout slack.
//   - FSM state encoding, kept as plain localparams for legacy tools.
package idc_conv_sequencer_pkg;

    localparam int unsigned DW_IN_DEF      = 29;
    localparam int unsigned N_W_DEF        = 11;
    localparam int unsigned DW_OUT_DEF     = 16;
    localparam int unsigned FIFO_DEPTH_DEF = 4;
    localparam int unsigned RST_CYC_DEF    = 3;
    localparam int unsigned TO_MARGIN_DEF  = 8;

    localparam int unsigned ST_W = 3;

    localparam logic [ST_W-1:0] StIdle    = 3'd0;
    localparam logic [ST_W-1:0] StLaunch  = 3'd1;
    localparam logic [ST_W-1:0] StConvert = 3'd2;
    localparam logic [ST_W-1:0] StSettle  = 3'd3;
    localparam logic [ST_W-1:0] StPush    = 3'd4;

endpackage

// File: rtl/idc_result_fifo.sv
// Synchronous first-word-fall-through result FIFO.
// Ports:
//   clk, rstb         clock, asynchronous active-low reset
//   push, push_data   write request and data (accepted when not full, or full with a pop)
//   pop               consume the head entry (ignored when empty)
//   head_data         current head, forced to zero while empty
//   full, empty       occupancy flags
module idc_result_fifo #(
    parameter int unsigned DW    = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk,
    input  logic          rstb,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head_data,
    output logic          full,
    output logic          empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == (AW+1)'(DEPTH));

    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot the push needs.
    assign do_push = push && (!full || do_pop);

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= push_data;
    end

    // Storage is not reset, so hide stale contents while empty.
    assign head_data = empty ? '0 : mem[rd_ptr_q];

endmodule

// File: rtl/idc_conv_sequencer.sv
// Control and readout stage for the L2min2 IDC reconstruction filter.
// Pulses the filter reset to launch a conversion, waits for done, captures the
// result, rounds/shifts/saturates it and queues it in a FWFT FIFO.
// Ports:
//   clk, rstb                  clock, asynchronous active-low reset
//   start, cont_mode           launch request, auto re-launch after each capture
//   n_cfg, shift_cfg           conversion length and result right-shift (sampled on start)
//   clr_err                    clears sticky error flags
//   filt_rst, filt_n           filter reset (active-high) and length
//   filt_done, filt_dout       filter completion and result
//   out_data, out_valid,
//   out_ready                  result stream (valid/ready)
//   busy                       sequencer not idle
//   err_ovf, err_to, err_cfg   sticky: FIFO overflow, timeout, zero length start
module idc_conv_sequencer
    import idc_conv_sequencer_pkg::*;
#(
    parameter int unsigned DW_IN      = DW_IN_DEF,
    parameter int unsigned N_W        = N_W_DEF,
    parameter int unsigned DW_OUT     = DW_OUT_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int unsigned RST_CYC    = RST_CYC_DEF,
    parameter int unsigned TO_MARGIN  = TO_MARGIN_DEF
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              start,
    input  logic              cont_mode,
    input  logic [N_W-1:0]    n_cfg,
    input  logic [4:0]        shift_cfg,
    input  logic              clr_err,
    output logic              filt_rst,
    output logic [N_W-1:0]    filt_n,
    input  logic              filt_done,
    input  logic [DW_IN-1:0]  filt_dout,
    output logic [DW_OUT-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              err_ovf,
    output logic              err_to,
    output logic              err_cfg
);

    // One extra bit so n + TO_MARGIN never wraps.
    localparam int unsigned CNT_W = N_W + 1;
    localparam logic [DW_IN:0] RoundOne = (DW_IN+1)'(1);

    logic [ST_W-1:0]   state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc, to_limit;
    logic [N_W-1:0]    n_q;
    logic [4:0]        shift_q;
    logic [DW_IN-1:0]  dout_q;
    logic              err_ovf_q, err_to_q, err_cfg_q;

    logic              latch_cfg, set_cfg, set_to, push;
    logic              fifo_full, fifo_empty, pop;
    logic [DW_IN:0]    round_add, sum, shifted;
    logic [DW_OUT-1:0] scaled;

    assign cnt_inc  = cnt_q + CNT_W'(1);
    assign to_limit = {1'b0, n_q} + CNT_W'(TO_MARGIN);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        latch_cfg = 1'b0;
        set_cfg   = 1'b0;
        set_to    = 1'b0;
        push      = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    if (n_cfg != '0) begin
                        latch_cfg = 1'b1;
                        cnt_d     = '0;
                        state_d   = StLaunch;
                    end else begin
                        set_cfg = 1'b1;
                    end
                end
            end
            StLaunch: begin
                if (cnt_q == CNT_W'(RST_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = StConvert;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StConvert: begin
                cnt_d = cnt_inc;
                // Done wins over a timeout hitting in the same cycle.
                if (filt_done) begin
                    state_d = StSettle;
                end else if (cnt_inc == to_limit) begin
                    set_to  = 1'b1;
                    state_d = StIdle;
                end
            end
            // Filter's final adder updates on the falling edge; dout_q loads here.
            StSettle: state_d = StPush;
            StPush: begin
                push    = 1'b1;
                cnt_d   = '0;
                state_d = cont_mode ? StLaunch : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            n_q     <= '0;
            shift_q <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (latch_cfg) begin
                n_q     <= n_cfg;
                shift_q <= shift_cfg;
            end
            if (state_q == StSettle) dout_q <= filt_dout;
        end
    end

    // Round half up, shift, then clamp to the unsigned output range.
    always_comb begin
        round_add = (shift_q == 5'd0) ? '0 : (RoundOne << (shift_q - 5'd1));
        sum       = {1'b0, dout_q} + round_add;
        shifted   = sum >> shift_q;
        scaled    = (|shifted[DW_IN:DW_OUT]) ? '1 : shifted[DW_OUT-1:0];
    end

    assign pop = out_valid && out_ready;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            err_ovf_q <= 1'b0;
            err_to_q  <= 1'b0;
            err_cfg_q <= 1'b0;
        end else if (clr_err) begin
            err_ovf_q <= 1'b0;
            err_to_q  <= 1'b0;
            err_cfg_q <= 1'b0;
        end else begin
            if (push && fifo_full && !pop) err_ovf_q <= 1'b1;
            if (set_to)                    err_to_q  <= 1'b1;
            if (set_cfg)                   err_cfg_q <= 1'b1;
        end
    end

    idc_result_fifo #(
        .DW    (DW_OUT),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rstb      (rstb),
        .push      (push),
        .push_data (scaled),
        .pop       (pop),
        .head_data (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Filter stays in reset except while it converts and its result settles.
    assign filt_rst  = !((state_q == StConvert) || (state_q == StSettle));
    assign filt_n    = n_q;
    assign out_valid = !fifo_empty;
    assign busy      = (state_q != StIdle);
    assign err_ovf   = err_ovf_q;
    assign err_to    = err_to_q;
    assign err_cfg   = err_cfg_q;

endmodule
